rw_port_arbiter: RTL and testbench
==================================

Name: rw_port_arbiter

Overview:
- Shares the single read/write data port of the external memory (8-bit address, 8-bit read/write data, write enable) between two requesters.
- Requester 0 is the mips core load/store path. Requester 1 is an auxiliary master such as a loader, DMA or debug unit.
- Sits between the masters and the memory. Provides req/gnt handshakes, round-robin fairness and a bounded burst length.

Parameters:
AW, 8, address width
DW, 8, data width
MAX_BURST, 4, maximum consecutive granted beats for one owner while the other requester waits (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
m0_req  in  1  requester 0 access request, held until granted
m0_we  in  1  requester 0 write (1) / read (0)
m0_addr  in  AW  requester 0 address
m0_wdata  in  DW  requester 0 write data
m0_gnt  out  1  requester 0 beat accepted this cycle
m0_rdata  out  DW  requester 0 registered read data
m0_rvalid  out  1  m0_rdata valid, one-cycle pulse
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid  same as m0_* for requester 1
mem_addr  out  AW  to memory rw address
mem_wdata  out  DW  to memory write data
mem_we  out  1  to memory write enable
mem_rdata  in  DW  from memory, combinational read of mem_addr
owner  out  2  00 idle, 01 requester 0, 10 requester 1

Behaviour:
- Memory model: write committed at the rising edge when mem_we=1. mem_rdata is valid in the same cycle as mem_addr.
- FSM states: IDLE, OWN0, OWN1. Registers: state, last (last owner), burst count bcnt (width clog2(MAX_BURST)+1), rdata/rvalid per port.
- Reset (rst=0, asynchronous) and all outputs:
  - state=IDLE, last=1 (so requester 0 wins first), bcnt=0.
  - m*_gnt=0, m*_rvalid=0, m*_rdata=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, owner=00.
- Reset mid-burst: the in-flight beat is dropped. No write occurs because mem_we is forced to 0 while rst=0.
- IDLE:
  - No request: stay.
  - Single request: go to its OWN state.
  - Both request: go to OWN(~last).
  - No grant is issued in IDLE. First-access latency from idle is 1 cycle.
- OWNx:
  - mx_gnt = mx_req (combinational). mem_* driven from port x. mem_we = mx_req & mx_we.
  - The non-owner's gnt is 0.
  - When mem_* is not driven by an owner, it is held at 0.
- Each granted beat increments bcnt.
- Transitions from OWNx, evaluated at the edge:
  - mx_req=0 and other requesting: go to OWN(other), bcnt=0, last=x.
  - mx_req=0 and other idle: go to IDLE, last=x.
  - mx_req=1, bcnt==MAX_BURST-1 and other requesting: go to OWN(other) after this beat, bcnt=0, last=x.
  - Otherwise stay. bcnt saturates at MAX_BURST-1 while the other port is idle.
- Back-to-back ownership switches cost no bubble. A switch via IDLE costs one.
- Read return: on a granted read beat, capture mem_rdata into mx_rdata at the edge and pulse mx_rvalid=1 for the next cycle. Read latency from gnt is 1 cycle.
- mx_rdata holds its value until the next read completes.
- A granted write produces no rvalid.
- Requester rule: req/we/addr/wdata must stay stable while req=1 and gnt=0. Behaviour is undefined otherwise.
- owner reflects the state register.

Optional Feature:
- Macro: RW_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_gnt0 and stat_gnt1 (16-bit granted-beat counters per port, saturating at 0xFFFF).
  - Adds output stat_conflict (16-bit, incremented each cycle both req are high and at most one is granted).
  - All counters clear on reset.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package rw_arb_pkg holds:
  - state encoding constants ST_IDLE=2'b00, ST_OWN0=2'b01, ST_OWN1=2'b10 (equal to the owner encoding);
  - default widths AW=8, DW=8;
  - the stats counter width of 16.
- One sub-module, rw_arb_rdreg: per-port read-capture register producing rdata and the rvalid pulse. It is instantiated twice.
- The FSM and mux stay in the top block.

Test Plan:
1. Reset release, m0_req read at addr 0x10 (memory holds 0x5A) -> owner=01 after 1 cycle, m0_gnt high 1 cycle, m0_rvalid pulse the next cycle with m0_rdata=0x5A. m1 outputs stay 0.
2. Both request continuously from IDLE after reset -> grants alternate in bursts of 4: m0 for 4 beats, then m1 for 4 beats, and so on. No cycle has both gnt high. No bubble at switches.
3. m1 writes 0x33 to addr 0xFF while m0 is idle -> mem_we=1, mem_addr=0xFF, mem_wdata=0x33 for exactly one cycle. A subsequent m0 read of 0xFF returns 0x33.
4. m0 burst of 10 reads with m1 idle -> all 10 granted consecutively, bcnt saturates, no switch. m1_req raised at beat 6 -> m1 is granted after at most 4 further m0 beats.
5. Assert rst=0 asynchronously mid-write beat -> mem_we drops immediately, state IDLE, all rvalid/gnt 0, and the memory location is unchanged.
6. With RW_ARB_STATS_EN, run scenario 2 for 16 cycles from first grant -> stat_gnt0=8, stat_gnt1=8, stat_conflict=16.

Source files
------------

// File: rtl/rw_arb_pkg.sv
// ---------------------------------------------------------------------------
// rw_arb_pkg
// Shared definitions for the read/write port arbiter slice.
//   - arb_state_t : FSM state encoding, identical to the 'owner' output code
//   - DEF_AW/DEF_DW : default address / data widths
//   - STAT_W : width of the optional statistics counters
// ---------------------------------------------------------------------------
package rw_arb_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
  localparam int STAT_W = 16;

  // The state code doubles as the owner code seen outside the block.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rw_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// rw_port_arbiter_if
// One requester-side memory access port of the arbiter.
//   req    : access request, held until granted
//   we     : write (1) / read (0)
//   addr   : access address
//   wdata  : write data
//   gnt    : beat accepted this cycle
//   rdata  : registered read data
//   rvalid : rdata valid, one-cycle pulse
// Modports: master (the requester), slave (the arbiter).
// ---------------------------------------------------------------------------
interface rw_port_arbiter_if
  import rw_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic [DW-1:0] rdata;
  logic          rvalid;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rdata, rvalid
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rdata, rvalid
  );

endinterface

// File: rtl/rw_arb_rdreg.sv
// ---------------------------------------------------------------------------
// rw_arb_rdreg
// Per-port read-return register. On a granted read beat the memory data is
// captured at the clock edge and rvalid pulses for the following cycle.
// rdata keeps its value until the next captured read.
//   clk     : system clock, rising edge
//   rst     : asynchronous reset, active-low
//   capture : granted read beat this cycle
//   din     : combinational memory read data
//   rdata   : registered read data
//   rvalid  : one-cycle valid pulse
// ---------------------------------------------------------------------------
module rw_arb_rdreg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] rdata,
  output logic          rvalid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= capture;
      if (capture) begin
        rdata <= din;
      end
    end
  end

endmodule

// File: rtl/rw_port_arbiter.sv
// ---------------------------------------------------------------------------
// rw_port_arbiter
// Shares one external read/write memory port between requester 0 (core
// load/store path) and requester 1 (loader / DMA / debug). Round-robin
// arbitration with a bounded burst length of MAX_BURST beats while the other
// requester waits.
//   clk       : system clock, rising edge
//   rst       : asynchronous reset, active-low
//   m0, m1    : requester ports (rw_port_arbiter_if.slave)
//   mem_addr  : memory address
//   mem_wdata : memory write data
//   mem_we    : memory write enable
//   mem_rdata : memory combinational read data of mem_addr
//   owner     : 00 idle, 01 requester 0, 10 requester 1
// Optional build macro RW_ARB_STATS_EN adds stat_gnt0, stat_gnt1 (saturating
// granted-beat counters) and stat_conflict (cycles with both requests high
// and at most one granted).
// ---------------------------------------------------------------------------
module rw_port_arbiter
  import rw_arb_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  rw_port_arbiter_if.slave  m0,
  rw_port_arbiter_if.slave  m1,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic              mem_we,
  input  logic [DW-1:0]     mem_rdata,
  output logic [1:0]        owner
`ifdef RW_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_gnt0,
  output logic [STAT_W-1:0] stat_gnt1,
  output logic [STAT_W-1:0] stat_conflict
`endif
);

  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BLAST = BW'(MAX_BURST - 1);

  arb_state_t    state;
  logic          last;
  logic [BW-1:0] bcnt;

  logic own0;
  logic own1;
  logic gnt0;
  logic gnt1;
  logic own_req;
  logic oth_req;

  assign own0 = (state == ST_OWN0);
  assign own1 = (state == ST_OWN1);

  // Grant is combinational: the owner's request is accepted in the same cycle.
  assign gnt0 = own0 & m0.req;
  assign gnt1 = own1 & m1.req;
  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;

  // Owner's and waiting requester's request, seen from the current owner.
  assign own_req = own1 ? m1.req : m0.req;
  assign oth_req = own1 ? m0.req : m1.req;

  assign owner = 2'(state);

  // Memory mux; held at zero when nobody owns the port. The write enable is
  // also gated by reset so a beat in flight when reset hits never writes.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (own0) begin
      mem_addr  = m0.addr;
      mem_wdata = m0.wdata;
      mem_we    = rst & m0.req & m0.we;
    end else if (own1) begin
      mem_addr  = m1.addr;
      mem_wdata = m1.wdata;
      mem_we    = rst & m1.req & m1.we;
    end
  end

  // Arbitration FSM. 'last' remembers who owned the port most recently so a
  // tie from IDLE goes to the other requester. bcnt counts granted beats of
  // the current owner and saturates at MAX_BURST-1 while the other side idles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      last  <= 1'b1;
      bcnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bcnt <= '0;
          if (m0.req && m1.req) begin
            state <= last ? ST_OWN0 : ST_OWN1;
          end else if (m0.req) begin
            state <= ST_OWN0;
          end else if (m1.req) begin
            state <= ST_OWN1;
          end
        end
        ST_OWN0, ST_OWN1: begin
          if (!own_req || (bcnt == BLAST && oth_req)) begin
            last <= own1;
            bcnt <= '0;
            if (oth_req) begin
              state <= own1 ? ST_OWN0 : ST_OWN1;
            end else begin
              state <= ST_IDLE;
            end
          end else if (bcnt != BLAST) begin
            bcnt <= bcnt + BW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          bcnt  <= '0;
        end
      endcase
    end
  end

  // Read-return registers, one per requester.
  rw_arb_rdreg #(.DW(DW)) u_rd0 (
    .clk     (clk),
    .rst     (rst),
    .capture (gnt0 & ~m0.we),
    .din     (mem_rdata),
    .rdata   (m0.rdata),
    .rvalid  (m0.rvalid)
  );

  rw_arb_rdreg #(.DW(DW)) u_rd1 (
    .clk     (clk),
    .rst     (rst),
    .capture (gnt1 & ~m1.we),
    .din     (mem_rdata),
    .rdata   (m1.rdata),
    .rvalid  (m1.rvalid)
  );

`ifdef RW_ARB_STATS_EN
  // Granted-beat counters saturate; the conflict counter counts cycles where
  // both requesters want the port (only one can ever be granted).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_gnt0     <= '0;
      stat_gnt1     <= '0;
      stat_conflict <= '0;
    end else begin
      if (gnt0 && (stat_gnt0 != '1)) begin
        stat_gnt0 <= stat_gnt0 + STAT_W'(1);
      end
      if (gnt1 && (stat_gnt1 != '1)) begin
        stat_gnt1 <= stat_gnt1 + STAT_W'(1);
      end
      if (m0.req && m1.req && !(gnt0 && gnt1)) begin
        stat_conflict <= stat_conflict + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rw_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rw_port_arbiter
// Directed bench for rw_port_arbiter with a 256x8 memory model. Inputs are
// driven 1 time unit after the rising edge and outputs sampled 1 unit later.
// ---------------------------------------------------------------------------
module tb_rw_port_arbiter;

  logic       clk;
  logic       rst;
  logic       preload;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic [1:0] owner;
  logic [7:0] mem [256];

  int checkCount;
  int errorCount;

`ifdef RW_ARB_STATS_EN
  logic [15:0] stat_gnt0;
  logic [15:0] stat_gnt1;
  logic [15:0] stat_conflict;
  logic [15:0] s0_start;
  logic [15:0] s1_start;
  logic [15:0] sc_start;
`endif

  rw_port_arbiter_if m0_if ();
  rw_port_arbiter_if m1_if ();

  rw_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .owner     (owner)
`ifdef RW_ARB_STATS_EN
    ,
    .stat_gnt0     (stat_gnt0),
    .stat_gnt1     (stat_gnt1),
    .stat_conflict (stat_conflict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Background memory contents: addr ^ 0xA5, except 0x10 holds 0x5A.
  function automatic logic [7:0] pat(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  // Memory model: preload while 'preload' is high, then commit writes.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] <= pat(8'(i));
      end
      mem[8'h10] <= 8'h5A;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [7:0] a0,
                               input logic [7:0] d0, input logic r1, input logic w1,
                               input logic [7:0] a1, input logic [7:0] d1);
    m0_if.req   = r0;
    m0_if.we    = w0;
    m0_if.addr  = a0;
    m0_if.wdata = d0;
    m1_if.req   = r1;
    m1_if.we    = w1;
    m1_if.addr  = a1;
    m1_if.wdata = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b0;
    preload = 1'b1;
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    tick();
    preload = 1'b0;
    #1;

    // Reset state
    checkOutput("rst_owner", 32'(owner), 32'h0);
    checkOutput("rst_gnt0", 32'(m0_if.gnt), 32'h0);
    checkOutput("rst_gnt1", 32'(m1_if.gnt), 32'h0);
    checkOutput("rst_rvalid0", 32'(m0_if.rvalid), 32'h0);
    checkOutput("rst_rvalid1", 32'(m1_if.rvalid), 32'h0);
    checkOutput("rst_rdata0", 32'(m0_if.rdata), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'h0);

    // Scenario 1: single m0 read of 0x10 from idle
    tick();
    rst = 1'b1;
    applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    #1;
    checkOutput("t1_idle_owner", 32'(owner), 32'h0);
    checkOutput("t1_idle_nogrant", 32'(m0_if.gnt), 32'h0);
    tick();
    #1;
    checkOutput("t1_owner", 32'(owner), 32'h1);
    checkOutput("t1_gnt0", 32'(m0_if.gnt), 32'h1);
    checkOutput("t1_gnt1", 32'(m1_if.gnt), 32'h0);
    checkOutput("t1_mem_addr", 32'(mem_addr), 32'h10);
    tick();
    applyStimulus(0, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    #1;
    checkOutput("t1_rvalid0", 32'(m0_if.rvalid), 32'h1);
    checkOutput("t1_rdata0", 32'(m0_if.rdata), 32'h5A);
    checkOutput("t1_gnt0_drop", 32'(m0_if.gnt), 32'h0);
    checkOutput("t1_rvalid1", 32'(m1_if.rvalid), 32'h0);
    checkOutput("t1_rdata1", 32'(m1_if.rdata), 32'h0);
    tick();
    #1;
    checkOutput("t1_back_idle", 32'(owner), 32'h0);
    checkOutput("t1_rvalid0_end", 32'(m0_if.rvalid), 32'h0);
    checkOutput("t1_rdata0_hold", 32'(m0_if.rdata), 32'h5A);

    // Scenario 2: both request continuously from a fresh reset
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    applyStimulus(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
    #1;
    checkOutput("t2_idle_gnt0", 32'(m0_if.gnt), 32'h0);
    checkOutput("t2_idle_gnt1", 32'(m1_if.gnt), 32'h0);
    for (int k = 0; k < 16; k++) begin
      tick();
      #1;
      checkOutput($sformatf("t2_gnt0_k%0d", k), 32'(m0_if.gnt), 32'((k % 8) < 4));
      checkOutput($sformatf("t2_gnt1_k%0d", k), 32'(m1_if.gnt), 32'((k % 8) >= 4));
      if (k == 0) begin
`ifdef RW_ARB_STATS_EN
        s0_start = stat_gnt0;
        s1_start = stat_gnt1;
        sc_start = stat_conflict;
`endif
      end
      if (k == 1) begin
        checkOutput("t2_rvalid0", 32'(m0_if.rvalid), 32'h1);
        checkOutput("t2_rdata0", 32'(m0_if.rdata), 32'hA4);
      end
      if (k == 5) begin
        checkOutput("t2_rvalid0_off", 32'(m0_if.rvalid), 32'h0);
        checkOutput("t2_rvalid1", 32'(m1_if.rvalid), 32'h1);
        checkOutput("t2_rdata1", 32'(m1_if.rdata), 32'hA7);
      end
    end
    tick();
    #1;
`ifdef RW_ARB_STATS_EN
    checkOutput("t6_stat_gnt0", 32'(stat_gnt0 - s0_start), 32'd8);
    checkOutput("t6_stat_gnt1", 32'(stat_gnt1 - s1_start), 32'd8);
    checkOutput("t6_stat_conflict", 32'(stat_conflict - sc_start), 32'd16);
`endif
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    #1;
    checkOutput("t2_idle_after", 32'(owner), 32'h0);

    // Scenario 3: m1 writes 0x33 to 0xFF, then m0 reads it back
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'hFF, 8'h33);
    #1;
    checkOutput("t3_idle_we", 32'(mem_we), 32'h0);
    tick();
    #1;
    checkOutput("t3_owner", 32'(owner), 32'h2);
    checkOutput("t3_gnt1", 32'(m1_if.gnt), 32'h1);
    checkOutput("t3_mem_we", 32'(mem_we), 32'h1);
    checkOutput("t3_mem_addr", 32'(mem_addr), 32'hFF);
    checkOutput("t3_mem_wdata", 32'(mem_wdata), 32'h33);
    tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'hFF, 8'h33);
    #1;
    checkOutput("t3_we_one_cycle", 32'(mem_we), 32'h0);
    checkOutput("t3_no_rvalid1", 32'(m1_if.rvalid), 32'h0);
    tick();
    applyStimulus(1, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00);
    #1;
    tick();
    #1;
    checkOutput("t3_gnt0", 32'(m0_if.gnt), 32'h1);
    tick();
    applyStimulus(0, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00);
    #1;
    checkOutput("t3_rvalid0", 32'(m0_if.rvalid), 32'h1);
    checkOutput("t3_rdata0", 32'(m0_if.rdata), 32'h33);
    tick();
    #1;
    checkOutput("t3_idle_after", 32'(owner), 32'h0);

    // Scenario 4: m0 burst of 10 reads with m1 idle, then m1 arrives
    applyStimulus(1, 0, 8'h20, 8'h00, 0, 0, 8'h40, 8'h00);
    #1;
    tick();
    for (int b = 1; b <= 11; b++) begin
      applyStimulus(1, 0, 8'(8'h20 + b - 1), 8'h00, (b == 11), 0, 8'h40, 8'h00);
      #1;
      checkOutput($sformatf("t4_gnt0_b%0d", b), 32'(m0_if.gnt), 32'h1);
      checkOutput($sformatf("t4_gnt1_b%0d", b), 32'(m1_if.gnt), 32'h0);
      checkOutput($sformatf("t4_addr_b%0d", b), 32'(mem_addr), 32'(8'h20 + b - 1));
      if (b >= 2) begin
        checkOutput($sformatf("t4_rdata_b%0d", b), 32'(m0_if.rdata),
                    32'(pat(8'(8'h20 + b - 2))));
      end
      tick();
    end
    applyStimulus(1, 0, 8'h2B, 8'h00, 1, 0, 8'h40, 8'h00);
    #1;
    checkOutput("t4_switch_owner", 32'(owner), 32'h2);
    checkOutput("t4_switch_gnt1", 32'(m1_if.gnt), 32'h1);
    checkOutput("t4_switch_gnt0", 32'(m0_if.gnt), 32'h0);
    checkOutput("t4_last_rdata0", 32'(m0_if.rdata), 32'h8F);
    tick();
    applyStimulus(1, 0, 8'h2B, 8'h00, 0, 0, 8'h40, 8'h00);
    #1;
    checkOutput("t4_rvalid1", 32'(m1_if.rvalid), 32'h1);
    checkOutput("t4_rdata1", 32'(m1_if.rdata), 32'(pat(8'h40)));
    checkOutput("t4_m0_waits", 32'(m0_if.gnt), 32'h0);
    tick();
    #1;
    checkOutput("t4_back_owner", 32'(owner), 32'h1);
    checkOutput("t4_back_addr", 32'(mem_addr), 32'h2B);
    tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    #1;
    checkOutput("t4_idle_after", 32'(owner), 32'h0);

    // Scenario 5: asynchronous reset in the middle of a write beat
    applyStimulus(1, 1, 8'h50, 8'hEE, 0, 0, 8'h00, 8'h00);
    #1;
    tick();
    #1;
    checkOutput("t5_we_before", 32'(mem_we), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t5_we_dropped", 32'(mem_we), 32'h0);
    checkOutput("t5_owner", 32'(owner), 32'h0);
    checkOutput("t5_gnt0", 32'(m0_if.gnt), 32'h0);
    checkOutput("t5_rvalid0", 32'(m0_if.rvalid), 32'h0);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    #1;
    checkOutput("t5_mem_unchanged", 32'(mem[8'h50]), 32'hF5);
    rst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
